// File: rtl/sar_adc_pkg.sv
// Shared constants for the SAR ADC controller: channel count, channel-select
// width and the FSM state encoding.
package sar_adc_pkg;

   localparam int NUM_CHAN = 6;
   localparam int CHAN_W   = 3;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_SAMPLE  = 2'd1;
   localparam state_t ST_CONVERT = 2'd2;
   localparam state_t ST_STORE   = 2'd3;

endpackage

// File: rtl/cmp_sync2.sv
// Two-flop synchroniser for the asynchronous comparator output.
// Both stages reset to 0.
module cmp_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: picks a channel, tracks for a fixed
// number of cycles, then walks the DAC code MSB-first against the comparator.
module sar_adc_ctrl
   import sar_adc_pkg::*;
#(
   parameter int N_BITS        = 8,
   parameter int SAMPLE_CYCLES = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                start,
   input  logic                cont,
   input  logic [NUM_CHAN-1:0] chan_mask,
   input  logic                cmp_in,
   output logic [CHAN_W-1:0]   mux_sel,
   output logic                sample_en,
   output logic [N_BITS-1:0]   dac_code,
   output logic                busy,
   output logic                done,
   output logic [N_BITS-1:0]   result,
   output logic [CHAN_W-1:0]   result_chan
);

   localparam int T_BIT   = SETTLE_CYCLES + 2;
   localparam int CNT_MAX = (SAMPLE_CYCLES > T_BIT) ? SAMPLE_CYCLES : T_BIT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

   localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  BIT_LAST    = CNT_W'(T_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_MSB     = IDX_W'(N_BITS - 1);
   localparam logic [N_BITS-1:0] MSB_CODE    = N_BITS'(1) << (N_BITS - 1);

   // Round-robin pick: first enabled channel strictly after 'last', wrapping.
   function automatic logic [CHAN_W-1:0] next_chan(
      input logic [NUM_CHAN-1:0] mask,
      input logic [CHAN_W-1:0]   last
   );
      logic [CHAN_W-1:0] pick;
      logic [CHAN_W-1:0] sel;
      logic              found;
      pick  = last;
      found = 1'b0;
      for (int off = 1; off <= NUM_CHAN; off++) begin
         sel = CHAN_W'((int'(last) + off) % NUM_CHAN);
         if (!found && mask[sel]) begin
            pick  = sel;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
   logic [N_BITS-1:0]   code_q, code_d;
   logic [CHAN_W-1:0]   mux_sel_q, mux_sel_d;
   logic [CHAN_W-1:0]   last_q, last_d;
   logic [N_BITS-1:0]   result_q, result_d;
   logic [CHAN_W-1:0]   result_chan_q, result_chan_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                sample_en_q, sample_en_d;

   logic                cmp_sync;
   logic [N_BITS-1:0]   trial;
   logic [N_BITS-1:0]   decided;

   cmp_sync2 u_cmp_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (cmp_in),
      .q     (cmp_sync)
   );

   assign trial = N_BITS'(1) << bit_idx_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bit_idx_d     = bit_idx_q;
      code_d        = code_q;
      mux_sel_d     = mux_sel_q;
      last_d        = last_q;
      result_d      = result_q;
      result_chan_d = result_chan_q;
      done_d        = 1'b0;
      decided       = code_q;

      if (!ena) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         code_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && (|chan_mask)) begin
                  mux_sel_d = next_chan(chan_mask, last_q);
                  state_d   = ST_SAMPLE;
                  cnt_d     = '0;
                  code_d    = '0;
               end
            end
            ST_SAMPLE: begin
               if (cnt_q == SAMPLE_LAST) begin
                  state_d   = ST_CONVERT;
                  cnt_d     = '0;
                  bit_idx_d = IDX_MSB;
                  code_d    = MSB_CODE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_CONVERT: begin
               // The synchronised comparator reflects this bit's trial code only in its last cycle.
               if (cnt_q == BIT_LAST) begin
                  decided = cmp_sync ? code_q : (code_q & ~trial);
                  cnt_d   = '0;
                  if (bit_idx_q == '0) begin
                     code_d  = decided;
                     state_d = ST_STORE;
                  end else begin
                     bit_idx_d = bit_idx_q - IDX_W'(1);
                     code_d    = decided | (trial >> 1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_STORE: begin
               result_d      = code_q;
               result_chan_d = mux_sel_q;
               last_d        = mux_sel_q;
               done_d        = 1'b1;
               code_d        = '0;
               cnt_d         = '0;
               if (cont && (|chan_mask)) begin
                  mux_sel_d = next_chan(chan_mask, mux_sel_q);
                  state_d   = ST_SAMPLE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               code_d  = '0;
            end
         endcase
      end

      // busy stays up through the cycle in which done is visible.
      busy_d      = (state_d != ST_IDLE) || done_d;
      sample_en_d = (state_d == ST_SAMPLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         code_q        <= '0;
         mux_sel_q     <= '0;
         last_q        <= CHAN_W'(NUM_CHAN - 1);
         result_q      <= '0;
         result_chan_q <= '0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         sample_en_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         code_q        <= code_d;
         mux_sel_q     <= mux_sel_d;
         last_q        <= last_d;
         result_q      <= result_d;
         result_chan_q <= result_chan_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
         sample_en_q   <= sample_en_d;
      end
   end

   assign mux_sel     = mux_sel_q;
   assign sample_en   = sample_en_q;
   assign dac_code    = code_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign result      = result_q;
   assign result_chan = result_chan_q;

endmodule
